// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_step_controller
//  Purpose  : Clock-enable sequencer for the single-cycle processor. Turns
//             debounced step/run button pulses into one-cycle processor
//             enables (single-step or free-running at a divided rate), stops
//             on a processor halt, and counts issued enables for display.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_step_controller #(
  parameter int RUN_DIV = 25_000_000,
  parameter int DIV_W   = 25
) (
  input  logic        CLK,
  input  logic        clear,
  input  logic        step_pulse,
  input  logic        run_pulse,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic        running,
  output logic        halted,
  output logic [15:0] step_count
);

  localparam logic [1:0] S_PAUSE  = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  // Divider restarts here on every RUN entry, so the first enable lands
  // exactly RUN_DIV edges after the entry edge.
  localparam logic [DIV_W-1:0] c_DIV_RELOAD = DIV_W'(RUN_DIV - 1);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_cpu_en;
  logic [15:0]      r_step_count;

  // Mode sequencing, divider and enable generation; halt beats run beats step.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state  <= S_PAUSE;
      r_cpu_en <= 1'b0;
      r_div    <= c_DIV_RELOAD;
    end else begin
      r_cpu_en <= 1'b0;
      case (r_state)
        S_PAUSE: begin
          if (halt_req) begin
            r_state <= S_HALTED;
          end else if (run_pulse) begin
            // A step arriving together with run is intentionally dropped.
            r_state <= S_RUN;
            r_div   <= c_DIV_RELOAD;
          end else if (step_pulse) begin
            r_cpu_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt_req) begin
            // Takes effect even when the divider is due; that enable is lost.
            r_state <= S_HALTED;
          end else if (run_pulse) begin
            r_state <= S_PAUSE;
          end else if (r_div == '0) begin
            r_cpu_en <= 1'b1;
            r_div    <= c_DIV_RELOAD;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        S_HALTED: begin
          // Leaving HALTED needs the processor to have dropped its request.
          if (run_pulse && !halt_req) begin
            r_state <= S_PAUSE;
          end
        end
        default: begin
          r_state <= S_PAUSE;
        end
      endcase
    end
  end

  // Count enables as they are issued; wraps silently at 16 bits.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_step_count <= 16'd0;
    end else if (r_cpu_en) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign cpu_en     = r_cpu_en;
  assign running    = (r_state == S_RUN);
  assign halted     = (r_state == S_HALTED);
  assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_step_controller
//  Purpose  : Self-checking bench for cpu_step_controller (RUN_DIV = 4),
//             scenario tasks plus randomized traffic against a mode/age model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_step_controller;

  localparam int RUN_DIV = 4;
  localparam int DIV_W   = 8;

  logic        CLK;
  logic        clear;
  logic        step_pulse;
  logic        run_pulse;
  logic        halt_req;
  logic        cpu_en;
  logic        running;
  logic        halted;
  logic [15:0] step_count;

  int n_cmp;
  int n_bad;

  cpu_step_controller #(
    .RUN_DIV (RUN_DIV),
    .DIV_W   (DIV_W)
  ) dut (
    .CLK        (CLK),
    .clear      (clear),
    .step_pulse (step_pulse),
    .run_pulse  (run_pulse),
    .halt_req   (halt_req),
    .cpu_en     (cpu_en),
    .running    (running),
    .halted     (halted),
    .step_count (step_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: mode, edges since RUN entry, expected outputs.
  // Mode: 0 = pause, 1 = run, 2 = halted.
  int          m_mode;
  int          m_age;
  bit          m_en;
  int          m_cnt;

  initial begin
    m_mode = 0;
    m_age  = 0;
    m_en   = 1'b0;
    m_cnt  = 0;
  end

  // Apply the behavioural rules at each rising edge using sampled inputs.
  always @(posedge CLK) begin
    bit nxt_en;
    nxt_en = 1'b0;
    if (clear) begin
      m_mode = 0;
      m_cnt  = 0;
    end else begin
      if (m_en) m_cnt = (m_cnt + 1) % 65536;
      if (m_mode == 0) begin
        if (halt_req)        m_mode = 2;
        else if (run_pulse)  begin m_mode = 1; m_age = 0; end
        else if (step_pulse) nxt_en = 1'b1;
      end else if (m_mode == 1) begin
        if (halt_req)       m_mode = 2;
        else if (run_pulse) m_mode = 0;
        else begin
          m_age = m_age + 1;
          if (m_age % RUN_DIV == 0) nxt_en = 1'b1;
        end
      end else begin
        if (run_pulse && !halt_req) m_mode = 0;
      end
    end
    m_en = nxt_en;
  end

  // Apply one cycle of inputs; outputs are settled 1 time unit after the edge.
  task automatic drive(input bit s, input bit r, input bit h, input bit c);
    step_pulse = s;
    run_pulse  = r;
    halt_req   = h;
    clear      = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    n_cmp++;
    if ({cpu_en, running, halted, step_count} !== {1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset: got en=%b run=%b halt=%b cnt=%h, want 0 0 0 0000",
               cpu_en, running, halted, step_count);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_single_step;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    n_cmp++;
    if ({cpu_en, running, step_count} !== {1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL step_issue: got en=%b run=%b cnt=%0d, want 1 0 0",
               cpu_en, running, step_count);
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({cpu_en, running, halted, step_count} !== {1'b0, 1'b0, 1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL step_after: got en=%b run=%b halt=%b cnt=%0d, want 0 0 0 1",
               cpu_en, running, halted, step_count);
    end
  endtask

  task automatic test_run_pause;
    int base;
    base = int'(step_count);
    drive(0, 1, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 0, 0);
      n_cmp++;
      if (cpu_en !== ((k % RUN_DIV) == 0) || running !== 1'b1) begin
        n_bad++;
        $display("FAIL run_cadence k=%0d: got en=%b run=%b, want en=%b run=1",
                 k, cpu_en, running, (k % RUN_DIV) == 0);
      end
    end
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (cpu_en !== 1'b0 || running !== 1'b0 || int'(step_count) !== base + 2) begin
      n_bad++;
      $display("FAIL run_pause: got en=%b run=%b cnt=%0d, want 0 0 %0d",
               cpu_en, running, step_count, base + 2);
    end
  endtask

  task automatic test_step_run_same;
    drive(1, 1, 0, 0);
    n_cmp++;
    if (cpu_en !== 1'b0 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL step_run_same: got en=%b run=%b, want 0 1", cpu_en, running);
    end
    for (int k = 1; k <= RUN_DIV; k++) begin
      drive(0, 0, 0, 0);
      n_cmp++;
      if (cpu_en !== (k == RUN_DIV)) begin
        n_bad++;
        $display("FAIL step_run_first k=%0d: got en=%b want %b", k, cpu_en, k == RUN_DIV);
      end
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_halt;
    int base;
    drive(0, 1, 0, 0);
    for (int k = 1; k < RUN_DIV; k++) drive(0, 0, 0, 0);
    base = int'(step_count);
    drive(1, 0, 1, 0);
    n_cmp++;
    if ({cpu_en, running, halted} !== 3'b001) begin
      n_bad++;
      $display("FAIL halt_on_due: got en=%b run=%b halt=%b, want 0 0 1",
               cpu_en, running, halted);
    end
    drive(1, 1, 1, 0);
    drive(1, 0, 1, 0);
    n_cmp++;
    if ({cpu_en, halted} !== 2'b01 || int'(step_count) !== base) begin
      n_bad++;
      $display("FAIL halt_hold: got en=%b halt=%b cnt=%0d, want 0 1 %0d",
               cpu_en, halted, step_count, base);
    end
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    n_cmp++;
    if ({running, halted} !== 2'b00) begin
      n_bad++;
      $display("FAIL halt_release: got run=%b halt=%b, want 0 0", running, halted);
    end
  endtask

  task automatic test_clear_mid_run;
    drive(0, 1, 0, 0);
    for (int k = 1; k < 2 * RUN_DIV; k++) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    n_cmp++;
    if ({cpu_en, running, halted, step_count} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL clear_mid_run: got en=%b run=%b halt=%b cnt=%0d, want 0 0 0 0",
               cpu_en, running, halted, step_count);
    end
    drive(0, 1, 0, 0);
    for (int k = 1; k <= RUN_DIV; k++) begin
      drive(0, 0, 0, 0);
      n_cmp++;
      if (cpu_en !== (k == RUN_DIV)) begin
        n_bad++;
        $display("FAIL clear_rerun k=%0d: got en=%b want %b", k, cpu_en, k == RUN_DIV);
      end
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_wrap;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (step_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_preload: got cnt=%h want ffff", step_count);
    end
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (step_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_rollover: got cnt=%h want 0000", step_count);
    end
    // Steps in RUN and HALTED must never produce an enable on their own.
    drive(0, 1, 0, 0);
    for (int k = 1; k < RUN_DIV; k++) begin
      drive(1, 0, 0, 0);
      n_cmp++;
      if (cpu_en !== 1'b0) begin
        n_bad++;
        $display("FAIL step_in_run k=%0d: got en=%b want 0", k, cpu_en);
      end
    end
    drive(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0);
      n_cmp++;
      if (cpu_en !== 1'b0 || halted !== 1'b1) begin
        n_bad++;
        $display("FAIL step_in_halt k=%0d: got en=%b halt=%b want 0 1", k, cpu_en, halted);
      end
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_random;
    bit h;
    h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) h = ~h;
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, h,
            $urandom_range(0, 59) == 0);
      n_cmp++;
      if (cpu_en !== m_en || running !== (m_mode == 1) || halted !== (m_mode == 2) ||
          int'(step_count) !== m_cnt) begin
        n_bad++;
        $display("FAIL random cyc=%0d: got en=%b run=%b halt=%b cnt=%0d, want en=%b run=%b halt=%b cnt=%0d",
                 i, cpu_en, running, halted, step_count,
                 m_en, m_mode == 1, m_mode == 2, m_cnt);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    clear      = 1'b1;
    step_pulse = 1'b0;
    run_pulse  = 1'b0;
    halt_req   = 1'b0;
    #1;
    test_reset();
    test_single_step();
    test_run_pause();
    test_step_run_same();
    test_halt();
    test_clear_mid_run();
    test_random();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_step_controller.md
# cpu_step_controller

Clock-enable sequencer between the debounced pushbutton pulse generators and the single-cycle processor datapath. It turns one-cycle `step_pulse` and `run_pulse` events into processor clock-enable pulses: single-step, or free-running at a divided rate. It stops automatically when the processor reports a halt, and keeps a count of issued enables for the display logic.

## Interface
Parameters:
- `RUN_DIV`, 25_000_000: CLK cycles between enables in RUN mode (4 Hz at 100 MHz). Legal range 2 .. 2^DIV_W−1.
- `DIV_W`, 25: width of the run-rate divider.

Ports:
- `CLK`  in  1  system clock (100 MHz), all logic on rising edge
- `clear`  in  1  reset, synchronous, active-high
- `step_pulse`  in  1  one-cycle pulse, debounced step button
- `run_pulse`  in  1  one-cycle pulse, debounced run/pause button (toggles)
- `halt_req`  in  1  level from processor decode (HALT instruction executed); synchronous to CLK
- `cpu_en`  out  1  registered one-cycle processor clock enable
- `running`  out  1  high while in RUN
- `halted`  out  1  high while in HALTED
- `step_count`  out  16  number of `cpu_en` pulses issued since reset

## Operation
- States: PAUSE (reset state), RUN, HALTED. Encoding is free; `running` and `halted` are decoded from state and registered-equivalent (no glitches).
- Reset (`clear`=1 at an edge): state←PAUSE, `cpu_en`←0, `step_count`←0, divider←RUN_DIV−1. This overrides every other input, including mid-RUN and mid-pulse.
- Priority in every state, highest first: `clear`, `halt_req`, `run_pulse`, `step_pulse`.
- PAUSE:
  - `halt_req`=1 → HALTED, `cpu_en`←0.
  - else `run_pulse` → RUN, divider←RUN_DIV−1, `cpu_en`←0. A `step_pulse` in the same cycle is dropped.
  - else `step_pulse` → stay PAUSE, `cpu_en`←1.
  - otherwise `cpu_en`←0.
- RUN:
  - `halt_req`=1 → HALTED, `cpu_en`←0. This applies even if the divider is at 0; the pending enable is suppressed.
  - else `run_pulse` → PAUSE, `cpu_en`←0.
  - else if divider==0: `cpu_en`←1, divider←RUN_DIV−1.
  - else: divider←divider−1, `cpu_en`←0.
  - `step_pulse` is ignored in RUN.
- HALTED:
  - `cpu_en`←0 always.
  - `run_pulse` with `halt_req`=0 → PAUSE.
  - `run_pulse` with `halt_req`=1 → stay HALTED.
  - `step_pulse` is ignored.
- `step_count`: increments by 1 on each edge at which `cpu_en` is 1 (i.e., it counts issued pulses). It wraps 0xFFFF→0x0000 without a flag.
- `cpu_en` is never high on two consecutive cycles, because RUN_DIV≥2 and step pulses are single-cycle.

## Timing
- Step latency: `step_pulse` sampled high at edge N → `cpu_en` high for the cycle following edge N, low after edge N+1. `step_count` updates at edge N+1.
- Run entry at edge N: the first `cpu_en` is set at edge N+RUN_DIV. After that, one `cpu_en` every RUN_DIV cycles exactly.
- Pause/halt take effect at the sampling edge, and no further `cpu_en` is issued.
  - A `cpu_en` already asserted by the previous edge completes its single cycle.
  - Re-entering RUN always restarts the divider at RUN_DIV−1; there is no phase carry-over.
- `running`/`halted` change at the same edge as the state.
- Outputs after reset: `cpu_en`=0, `running`=0, `halted`=0, `step_count`=0.

## Test plan
All scenarios use RUN_DIV=4.
- Reset then a single `step_pulse` at edge 10 → `cpu_en` high only in the cycle after edge 10; `step_count`=1; state remains PAUSE.
- `run_pulse` at edge 20, no other input → `cpu_en` set at edges 24, 28, 32, … (1 cycle wide each), `running`=1; `run_pulse` at edge 30 → no enable at 32, `running`=0, `step_count`=2.
- Simultaneous `step_pulse`+`run_pulse` in PAUSE → enters RUN, no immediate `cpu_en`; first enable 4 edges later.
- `halt_req` raised on the edge where the divider is 0 in RUN → `cpu_en` stays 0, `halted`=1; then `run_pulse` with `halt_req`=1 → still HALTED; drop `halt_req`, then `run_pulse` → PAUSE, `halted`=0.
- `clear` asserted mid-RUN on the edge where the divider is 0 → `cpu_en`=0, `step_count`=0, PAUSE; the next `run_pulse` gives its first enable 4 edges later.
- Preload via 65535 step pulses, then one more → `step_count` wraps to 0x0000; `step_pulse` during RUN/HALTED never raises `cpu_en`.
